const_step_sequencer: RTL and testbench

- Parametrised successor to the fixed constant-per-state test FSMs.
- Steps through a programmable table of NUM_STEPS constants and drives one constant per step onto out_data, holding each step for a programmable dwell time.
- Supports one-shot or looping runs, and start/stop control.
- Used as a stimulus and constant source in unit-test harnesses and small datapaths.

---
 rtl/const_step_sequencer.sv | 151 +++++++++++++++
 tb/tb_const_step_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_step_sequencer.sv
// ============================================================================
// Module   : const_step_sequencer
// Purpose  : Steps through a programmable table of constants, one per step,
//            with a per-step dwell time. One-shot or looping runs, start/stop.
// Option   : CONST_STEP_SEQ_PARITY_EN adds the registered out_parity output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module const_step_sequencer #(
    parameter int DATA_W    = 32,
    parameter int NUM_STEPS = 8,
    parameter int DWELL_W   = 4,
    parameter int STATE_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]            cfg_data,
    input  logic [DWELL_W-1:0]           cfg_dwell,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_mode,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_flag,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy,
    output logic                         done
`ifdef CONST_STEP_SEQ_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam int TBL_D = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

    typedef enum logic [STATE_W-1:0] {
        S_INIT = STATE_W'(0),
        S_IDLE = STATE_W'(1),
        S_RUN  = STATE_W'(2),
        S_DONE = STATE_W'(3)
    } state_t;

    state_t              fsm_state;
    logic [DATA_W-1:0]   const_tbl [TBL_D];
    logic [DWELL_W-1:0]  dwell_tbl [TBL_D];
    logic [DWELL_W-1:0]  dwell_cnt;
    logic [IDX_W-1:0]    next_idx;

    // Wrap target is only taken when loop_mode allows it at the last step.
    always_comb begin
        next_idx = (step_idx == LAST_IDX) ? '0 : step_idx + 1'b1;
    end

    // Table storage; reads on the write edge see the previous contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_D; i++) begin
                const_tbl[i] <= '0;
                dwell_tbl[i] <= '0;
            end
        end else if (cfg_we && (fsm_state != S_INIT)) begin
            const_tbl[cfg_addr] <= cfg_data;
            dwell_tbl[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state  <= S_INIT;
            out_data   <= '0;
            out_flag   <= 1'b0;
            step_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dwell_cnt  <= '0;
`ifdef CONST_STEP_SEQ_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            case (fsm_state)
                S_INIT: begin
                    fsm_state <= S_IDLE;
                end
                S_IDLE, S_DONE: begin
                    if (start && !stop) begin
                        fsm_state  <= S_RUN;
                        step_idx   <= '0;
                        out_data   <= const_tbl[0];
                        out_flag   <= (const_tbl[0] != '0);
                        dwell_cnt  <= dwell_tbl[0];
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef CONST_STEP_SEQ_PARITY_EN
                        out_parity <= ^const_tbl[0];
`endif
                    end else if (stop) begin
                        fsm_state  <= S_IDLE;
                        done       <= 1'b0;
                        out_data   <= '0;
                        out_flag   <= 1'b0;
`ifdef CONST_STEP_SEQ_PARITY_EN
                        out_parity <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        fsm_state  <= S_IDLE;
                        out_data   <= '0;
                        out_flag   <= 1'b0;
                        busy       <= 1'b0;
`ifdef CONST_STEP_SEQ_PARITY_EN
                        out_parity <= 1'b0;
`endif
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if ((step_idx != LAST_IDX) || loop_mode) begin
                        step_idx   <= next_idx;
                        out_data   <= const_tbl[next_idx];
                        out_flag   <= (const_tbl[next_idx] != '0);
                        dwell_cnt  <= dwell_tbl[next_idx];
`ifdef CONST_STEP_SEQ_PARITY_EN
                        out_parity <= ^const_tbl[next_idx];
`endif
                    end else begin
                        fsm_state <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    fsm_state  <= S_INIT;
                    out_data   <= '0;
                    out_flag   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
`ifdef CONST_STEP_SEQ_PARITY_EN
                    out_parity <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_const_step_sequencer.sv
// ============================================================================
// Module   : tb_const_step_sequencer
// Purpose  : Directed bench for const_step_sequencer with a queued scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_const_step_sequencer;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [3:0]  cfg_dwell;
    logic        start;
    logic        stop;
    logic        loop_mode;
    logic [31:0] out_data;
    logic        out_flag;
    logic [1:0]  step_idx;
    logic        busy;
    logic        done;
`ifdef CONST_STEP_SEQ_PARITY_EN
    logic        out_parity;
`endif

    const_step_sequencer #(
        .DATA_W    (32),
        .NUM_STEPS (4),
        .DWELL_W   (4),
        .STATE_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_dwell  (cfg_dwell),
        .start      (start),
        .stop       (stop),
        .loop_mode  (loop_mode),
        .out_data   (out_data),
        .out_flag   (out_flag),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
`ifdef CONST_STEP_SEQ_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic        flag;
        logic [1:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required summary before 200000");
        $fatal(1, "watchdog");
    end

    // Monitor: each RUN cycle and each entry into DONE consumes one expectation.
    initial begin
        logic done_q;
        exp_t got;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && (busy || (done && !done_q))) begin
                got = '{out_data, out_flag, step_idx, busy, done};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected: got data=%h flag=%b idx=%0d busy=%b done=%b, required no output",
                             got.data, got.flag, got.idx, got.busy, got.done);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL mon: got data=%h flag=%b idx=%0d busy=%b done=%b, required data=%h flag=%b idx=%0d busy=%b done=%b",
                                 got.data, got.flag, got.idx, got.busy, got.done,
                                 e.data, e.flag, e.idx, e.busy, e.done);
                    end
                end
            end
            done_q = reset ? 1'b0 : done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic f, input logic [1:0] i,
                        input logic b, input logic dn);
        exp_t e;
        e = '{d, f, i, b, dn};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] dw);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_dwell = dw;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_dwell = '0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
        #3;
        check("rst_data", out_data, 32'h0);
        check("rst_flag", {31'b0, out_flag}, 32'h0);
        check("rst_busy_done", {30'b0, busy, done}, 32'h0);
        repeat (2) tick();
        reset = 1'b0;

        // INIT edge: write and start must both be ignored
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'h55; cfg_dwell = 4'd3; start = 1'b1;
        tick();
        check("init_no_start", {31'b0, busy}, 32'h0);
        cfg_we = 1'b0;
        push(32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("first_stop_busy", {31'b0, busy}, 32'h0);

        wr(2'd0, 32'd0, 4'd0);
        wr(2'd1, 32'd1, 4'd0);
        wr(2'd2, 32'd15, 4'd1);
        wr(2'd3, 32'd9, 4'd0);

        start = 1'b1; stop = 1'b1;
        tick();
        check("stop_prio_busy", {31'b0, busy}, 32'h0);
        start = 1'b0; stop = 1'b0;
        tick();
        check("stop_prio_idle", {30'b0, busy, done}, 32'h0);

        // One-shot: 0,1,15,15,9 then DONE holding 9
        loop_mode = 1'b0;
        push(32'd0,  1'b0, 2'd0, 1'b1, 1'b0);
        push(32'd1,  1'b1, 2'd1, 1'b1, 1'b0);
        push(32'd15, 1'b1, 2'd2, 1'b1, 1'b0);
        push(32'd15, 1'b1, 2'd2, 1'b1, 1'b0);
        push(32'd9,  1'b1, 2'd3, 1'b1, 1'b0);
        push(32'd9,  1'b1, 2'd3, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("oneshot_done", {31'b0, done}, 32'h1);
        check("oneshot_hold", out_data, 32'd9);
        repeat (2) tick();
        check("done_held", {30'b0, busy, done}, 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("done_stop_done", {31'b0, done}, 32'h0);
        check("done_stop_data", out_data, 32'h0);

        // Loop with write landing on the edge that enters step 1
        loop_mode = 1'b1;
        push(32'd0,        1'b0, 2'd0, 1'b1, 1'b0);
        push(32'd1,        1'b1, 2'd1, 1'b1, 1'b0);
        push(32'd15,       1'b1, 2'd2, 1'b1, 1'b0);
        push(32'd15,       1'b1, 2'd2, 1'b1, 1'b0);
        push(32'd9,        1'b1, 2'd3, 1'b1, 1'b0);
        push(32'd0,        1'b0, 2'd0, 1'b1, 1'b0);
        push(32'hA5A5A5A5, 1'b1, 2'd1, 1'b1, 1'b0);
        push(32'd15,       1'b1, 2'd2, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 32'hA5A5A5A5; cfg_dwell = 4'd0;
        tick();
        cfg_we = 1'b0;
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("run_stop_data", out_data, 32'h0);
        check("run_stop_idx", {30'b0, step_idx}, 32'd2);
        check("run_stop_busy_done", {30'b0, busy, done}, 32'h0);

        // Asynchronous reset mid-run
        push(32'd0,        1'b0, 2'd0, 1'b1, 1'b0);
        push(32'hA5A5A5A5, 1'b1, 2'd1, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_data", out_data, 32'h0);
        check("async_rst_idx_flag", {29'b0, step_idx, out_flag}, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("init2_no_start", {31'b0, busy}, 32'h0);
        push(32'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        push(32'd0, 1'b0, 2'd1, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;

`ifdef CONST_STEP_SEQ_PARITY_EN
        wr(2'd0, 32'h7, 4'd0);
        wr(2'd1, 32'h3, 4'd0);
        loop_mode = 1'b0;
        push(32'h7, 1'b1, 2'd0, 1'b1, 1'b0);
        push(32'h3, 1'b1, 2'd1, 1'b1, 1'b0);
        push(32'h0, 1'b0, 2'd2, 1'b1, 1'b0);
        push(32'h0, 1'b0, 2'd3, 1'b1, 1'b0);
        push(32'h0, 1'b0, 2'd3, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("parity_7", {31'b0, out_parity}, 32'h1);
        tick();
        check("parity_3", {31'b0, out_parity}, 32'h0);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
